// File: rtl/cmp_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cmp_pkg : shared types and helpers for the 32-bit peak tracker        |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package cmp_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      FIRST = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   // Index width never drops below one bit, even for single-sample windows.
   function automatic int calc_idx_w(input int win_len);
      return (win_len > 2) ? $clog2(win_len) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/peak_cmp_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | peak_cmp_stage : compares a sample against the running max and min.   |
// | Build option PEAK_SIGNED_EN selects two's-complement comparison.      |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module peak_cmp_stage
   import cmp_pkg::*;
(
   input  logic [DATA_W-1:0] sample,
   input  logic [DATA_W-1:0] run_max,
   input  logic [DATA_W-1:0] run_min,
   output logic              upd_max,
   output logic              upd_min,
   output logic              neq
);

`ifdef PEAK_SIGNED_EN
   assign upd_max = $signed(sample) > $signed(run_max);
   assign upd_min = $signed(sample) < $signed(run_min);
`else
   assign upd_max = sample > run_max;
   assign upd_min = sample < run_min;
`endif

   assign neq = (sample != run_max) || (sample != run_min);

endmodule
`default_nettype wire

// File: rtl/cmp32_peak_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cmp32_peak_tracker : reduces each WIN_LEN-sample window to max/min    |
// | and their first indices. Build option PEAK_SIGNED_EN: signed compare. |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module cmp32_peak_tracker
   import cmp_pkg::*;
#(
   parameter  int WIN_LEN = 16,
   localparam int IDX_W   = calc_idx_w(WIN_LEN)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_max,
   output logic [DATA_W-1:0] out_min,
   output logic [IDX_W-1:0]  out_max_idx,
   output logic [IDX_W-1:0]  out_min_idx,
   output logic              out_all_eq
);

   localparam logic [IDX_W-1:0] c_LAST = IDX_W'(WIN_LEN - 1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [IDX_W-1:0]  r_count;
   logic [DATA_W-1:0] r_max;
   logic [DATA_W-1:0] r_min;
   logic [IDX_W-1:0]  r_max_idx;
   logic [IDX_W-1:0]  r_min_idx;
   logic              r_all_eq;
   logic              w_accept;
   logic              w_upd_max;
   logic              w_upd_min;
   logic              w_neq;

   peak_cmp_stage u_cmp (
      .sample  (in_data),
      .run_max (r_max),
      .run_min (r_min),
      .upd_max (w_upd_max),
      .upd_min (w_upd_min),
      .neq     (w_neq)
   );

   assign w_accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FIRST;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Handshake flags derive from state alone; out_ready only steers the next state.
   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      case (r_state)
         FIRST: begin
            in_ready = 1'b1;
            if (in_valid) begin
               w_state_nxt = (WIN_LEN == 1) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && (r_count == c_LAST)) begin
               w_state_nxt = HOLD;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               w_state_nxt = FIRST;
            end
         end
         default: w_state_nxt = FIRST;
      endcase
      if (clear) begin
         w_state_nxt = FIRST;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count   <= '0;
         r_max     <= '0;
         r_min     <= '0;
         r_max_idx <= '0;
         r_min_idx <= '0;
         r_all_eq  <= 1'b0;
      end else if (clear) begin
         r_count <= '0;
      end else if (w_accept) begin
         if (r_state == FIRST) begin
            r_max     <= in_data;
            r_min     <= in_data;
            r_max_idx <= '0;
            r_min_idx <= '0;
            r_all_eq  <= 1'b1;
            r_count   <= IDX_W'(1);
         end else begin
            // Strict compares leave ties on the earliest index.
            if (w_upd_max) begin
               r_max     <= in_data;
               r_max_idx <= r_count;
            end
            if (w_upd_min) begin
               r_min     <= in_data;
               r_min_idx <= r_count;
            end
            if (w_neq) begin
               r_all_eq <= 1'b0;
            end
            if (r_count != c_LAST) begin
               r_count <= r_count + IDX_W'(1);
            end
         end
      end
   end

   assign out_max     = r_max;
   assign out_min     = r_min;
   assign out_max_idx = r_max_idx;
   assign out_min_idx = r_min_idx;
   assign out_all_eq  = r_all_eq;

endmodule
`default_nettype wire

// File: tb/tb_cmp32_peak_tracker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_cmp32_peak_tracker : self-checking bench, WIN_LEN=4 and WIN_LEN=1  |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module tb_cmp32_peak_tracker;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clear;
   logic        in_valid, in_ready, out_valid, out_ready, out_all_eq;
   logic [31:0] in_data, out_max, out_min;
   logic [1:0]  out_max_idx, out_min_idx;

   logic        in_valid1, in_ready1, out_valid1, out_ready1, out_all_eq1;
   logic [31:0] in_data1, out_max1, out_min1;
   logic [0:0]  out_max_idx1, out_min_idx1;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] win_q[$];
   logic [68:0] exp_res;
   logic [68:0] act4;

   assign act4 = {out_max, out_min, out_max_idx, out_min_idx, out_all_eq};

   always #5 clk = ~clk;

   cmp32_peak_tracker #(.WIN_LEN(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_max(out_max), .out_min(out_min),
      .out_max_idx(out_max_idx), .out_min_idx(out_min_idx), .out_all_eq(out_all_eq)
   );

   cmp32_peak_tracker #(.WIN_LEN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
      .out_valid(out_valid1), .out_ready(out_ready1),
      .out_max(out_max1), .out_min(out_min1),
      .out_max_idx(out_max_idx1), .out_min_idx(out_min_idx1), .out_all_eq(out_all_eq1)
   );

   function automatic logic gt(input logic [31:0] a, input logic [31:0] b);
`ifdef PEAK_SIGNED_EN
      return $signed(a) > $signed(b);
`else
      return a > b;
`endif
   endfunction

   // Reference: find the extreme values first, then the first position holding each.
   function automatic logic [68:0] model();
      logic [31:0] mx, mn;
      int          mxi, mni;
      logic        eq;
      mx = win_q[0];
      mn = win_q[0];
      eq = 1'b1;
      foreach (win_q[i]) begin
         if (gt(win_q[i], mx)) mx = win_q[i];
         if (gt(mn, win_q[i])) mn = win_q[i];
         if (win_q[i] != win_q[0]) eq = 1'b0;
      end
      mxi = -1;
      mni = -1;
      foreach (win_q[i]) begin
         if (mxi < 0 && win_q[i] == mx) mxi = i;
         if (mni < 0 && win_q[i] == mn) mni = i;
      end
      return {mx, mn, 2'(mxi), 2'(mni), eq};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents one sample to dut4 and advances through its acceptance edge.
   task automatic feed(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      for (int t = 0; t < 50 && !in_ready; t++) step();
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL feed_timeout: in_ready=%0b required 1", in_ready);
      end
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      n_checks++;
      if ({out_valid, in_ready, act4} !== {1'b1 ^ 1'b1, 1'b1, 69'd0}) begin
         n_fail++;
         $display("FAIL reset_state: got v=%0b r=%0b res=%h required v=0 r=1 res=0", out_valid, in_ready, act4);
      end
      n_checks++;
      if ({out_valid1, in_ready1, out_max1, out_min1, out_all_eq1} !== {1'b0, 1'b1, 65'd0}) begin
         n_fail++;
         $display("FAIL reset_state_w1: got v=%0b r=%0b max=%h", out_valid1, in_ready1, out_max1);
      end
      rst_n = 1'b1;
      step();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_release: got v=%0b r=%0b required v=0 r=1", out_valid, in_ready);
      end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      win_q = '{32'd5, 32'd9, 32'd2, 32'd9};
      for (int i = 0; i < 3; i++) feed(win_q[i]);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_early_valid: got %0b required 0", out_valid);
      end
      feed(win_q[3]);
      in_valid = 1'b0;
      exp_res = {32'd9, 32'd2, 2'd1, 2'd2, 1'b0};
      n_checks++;
      if ({out_valid, in_ready, act4} !== {2'b10, exp_res}) begin
         n_fail++;
         $display("FAIL basic_result: got v=%0b r=%0b res=%h required v=1 r=0 res=%h", out_valid, in_ready, act4, exp_res);
      end
      step();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL basic_handshake: got v=%0b r=%0b required v=0 r=1", out_valid, in_ready);
      end
   endtask

   task automatic test_all_eq();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) feed(32'h1234_5678);
      in_valid = 1'b0;
      exp_res = {32'h1234_5678, 32'h1234_5678, 2'd0, 2'd0, 1'b1};
      n_checks++;
      if ({out_valid, act4} !== {1'b1, exp_res}) begin
         n_fail++;
         $display("FAIL all_eq: got v=%0b res=%h required v=1 res=%h", out_valid, act4, exp_res);
      end
      step();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      win_q = '{32'd40, 32'd20, 32'd60, 32'd20};
      foreach (win_q[i]) feed(win_q[i]);
      exp_res = model();
      in_valid = 1'b1;
      in_data  = 32'd1;
      for (int c = 0; c < 5; c++) begin
         n_checks++;
         if ({out_valid, in_ready, act4} !== {2'b10, exp_res}) begin
            n_fail++;
            $display("FAIL bp_hold cyc%0d: got v=%0b r=%0b res=%h required v=1 r=0 res=%h", c, out_valid, in_ready, act4, exp_res);
         end
         step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL bp_release: got v=%0b r=%0b required v=0 r=1", out_valid, in_ready);
      end
      win_q = '{32'd1, 32'd10, 32'd10, 32'd2};
      foreach (win_q[i]) feed(win_q[i]);
      in_valid = 1'b0;
      exp_res = {32'd10, 32'd1, 2'd1, 2'd0, 1'b0};
      n_checks++;
      if ({out_valid, act4} !== {1'b1, exp_res}) begin
         n_fail++;
         $display("FAIL bp_next_window: got v=%0b res=%h required v=1 res=%h", out_valid, act4, exp_res);
      end
      out_ready = 1'b1;
      step();
   endtask

   task automatic test_signedness();
      out_ready = 1'b1;
      win_q = '{32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001};
      foreach (win_q[i]) feed(win_q[i]);
      in_valid = 1'b0;
`ifdef PEAK_SIGNED_EN
      exp_res = {32'h0000_0001, 32'hFFFF_FFFF, 2'd1, 2'd0, 1'b0};
`else
      exp_res = {32'hFFFF_FFFF, 32'h0000_0001, 2'd0, 2'd1, 1'b0};
`endif
      n_checks++;
      if ({out_valid, act4} !== {1'b1, exp_res}) begin
         n_fail++;
         $display("FAIL signedness: got v=%0b res=%h required v=1 res=%h", out_valid, act4, exp_res);
      end
      step();
   endtask

   task automatic test_clear();
      out_ready = 1'b0;
      feed(32'd100);
      feed(32'd0);
      clear    = 1'b1;
      in_data  = 32'd50;
      step();
      clear    = 1'b0;
      in_valid = 1'b0;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL clear_mid: got v=%0b r=%0b required v=0 r=1", out_valid, in_ready);
      end
      win_q = '{32'd7, 32'd3, 32'd8, 32'd1};
      foreach (win_q[i]) feed(win_q[i]);
      in_valid = 1'b0;
      exp_res = {32'd8, 32'd1, 2'd2, 2'd3, 1'b0};
      n_checks++;
      if ({out_valid, act4} !== {1'b1, exp_res}) begin
         n_fail++;
         $display("FAIL clear_result: got v=%0b res=%h required v=1 res=%h", out_valid, act4, exp_res);
      end
      clear = 1'b1;
      step();
      clear = 1'b0;
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL clear_hold: got v=%0b r=%0b required v=0 r=1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid_hold();
      out_ready = 1'b0;
      foreach (win_q[i]) feed(win_q[i] + 32'd3);
      in_valid = 1'b0;
      n_checks++;
      if (out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_hold_pre: got v=%0b required 1", out_valid);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, act4} !== 70'd0) begin
         n_fail++;
         $display("FAIL rst_hold_async: got v=%0b res=%h required v=0 res=0", out_valid, act4);
      end
      step();
      rst_n = 1'b1;
      step();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL rst_hold_release: got v=%0b r=%0b required v=0 r=1", out_valid, in_ready);
      end
   endtask

   task automatic test_win1();
      out_ready1 = 1'b0;
      in_valid1  = 1'b1;
      in_data1   = 32'd42;
      step();
      in_valid1 = 1'b0;
      n_checks++;
      if ({out_valid1, in_ready1, out_max1, out_min1, out_max_idx1, out_min_idx1, out_all_eq1}
          !== {2'b10, 32'd42, 32'd42, 1'b0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL win1_result: got v=%0b r=%0b max=%0d min=%0d eq=%0b required v=1 r=0 max=42 min=42 eq=1",
                  out_valid1, in_ready1, out_max1, out_min1, out_all_eq1);
      end
      out_ready1 = 1'b1;
      step();
      out_ready1 = 1'b0;
      n_checks++;
      if ({out_valid1, in_ready1} !== 2'b01) begin
         n_fail++;
         $display("FAIL win1_handshake: got v=%0b r=%0b required v=0 r=1", out_valid1, in_ready1);
      end
   endtask

   task automatic test_random();
      int bound;
      for (int w = 0; w < 25; w++) begin
         out_ready = 1'b0;
         win_q = {};
         for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
               0:       win_q.push_back(32'($urandom_range(0, 3)));
               1:       win_q.push_back(32'h8000_0000 + 32'($urandom_range(0, 1)));
               default: win_q.push_back($urandom);
            endcase
         end
         foreach (win_q[i]) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) step();
            feed(win_q[i]);
         end
         in_valid = 1'b0;
         bound = 0;
         while (!out_valid && bound < 20) begin
            step();
            bound++;
         end
         repeat ($urandom_range(0, 3)) step();
         exp_res = model();
         n_checks++;
         if ({out_valid, act4} !== {1'b1, exp_res}) begin
            n_fail++;
            $display("FAIL random_w%0d: got v=%0b res=%h required v=1 res=%h", w, out_valid, act4, exp_res);
         end
         out_ready = 1'b1;
         step();
      end
      out_ready = 1'b0;
   endtask

   initial begin
      clear      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      in_valid1  = 1'b0;
      in_data1   = '0;
      out_ready1 = 1'b0;
      test_reset();
      test_basic();
      test_all_eq();
      test_backpressure();
      test_signedness();
      test_clear();
      test_reset_mid_hold();
      test_win1();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cmp32_peak_tracker.md
Name: cmp32_peak_tracker

Overview:
- Streaming stage that consumes 32-bit samples and reduces each window of WIN_LEN samples to its maximum, its minimum, and the index of each.
- Built on a 32-bit magnitude compare (gt/lt/eq) against the running max and running min.
- Result is a single beat on a valid/ready output port.
- Sits directly downstream of the sample source and upstream of the statistics/alarm logic.

Parameters:
- WIN_LEN, 16, samples per window; legal range 1..65535.
- IDX_W, $clog2(WIN_LEN) with a minimum of 1, width of the index outputs; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort of the current window; highest priority.
- in_valid  in  1  sample valid.
- in_ready  out  1  block accepts a sample.
- in_data  in  32  sample.
- out_valid  out  1  window result valid.
- out_ready  in  1  consumer accepts the result.
- out_max  out  32  window maximum.
- out_min  out  32  window minimum.
- out_max_idx  out  IDX_W  position of the maximum in the window (0-based).
- out_min_idx  out  IDX_W  position of the minimum in the window (0-based).
- out_all_eq  out  1  every sample in the window equals the first sample.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: state=FIRST; count=0; out_valid=0; out_max, out_min, out_max_idx, out_min_idx and out_all_eq = 0. in_ready=1 while in FIRST.
- A sample is accepted when in_valid && in_ready on a rising edge.
- State FIRST:
  - Accepted sample loads run_max=run_min=in_data, max_idx=min_idx=0, all_eq=1, count=1.
  - If WIN_LEN==1, go to HOLD; otherwise go to ACCUM.
- State ACCUM:
  - Accepted sample is compared against run_max and run_min in the same cycle.
  - in_data > run_max (strict): replace run_max, max_idx=count.
  - in_data < run_min (strict): replace run_min, min_idx=count.
  - Ties keep the earliest occurrence.
  - in_data != run_max or in_data != run_min: all_eq=0.
  - count increments. When the accepted sample is the last one (count==WIN_LEN-1), go to HOLD.
- State HOLD:
  - in_ready=0; out_valid=1.
  - Outputs reflect the final running values and must stay stable while out_valid && !out_ready.
  - On out_valid && out_ready: out_valid=0 next cycle, go to FIRST.
  - The next sample can be accepted the cycle after the handshake; there is no same-cycle bypass.
- Latency: out_valid rises on the edge that accepts the last sample, so it is visible one cycle after that sample's handshake cycle.
- Throughput: one sample per cycle while in FIRST or ACCUM.
- in_ready depends only on state, with no combinational path from out_ready.
- clear:
  - Next state FIRST, count=0, out_valid=0.
  - Beats on either port in the clear cycle are discarded.
  - out_* data may hold stale values but are don't-care while out_valid=0.
- in_valid low mid-window: state and counters hold indefinitely.
- Reset mid-window or mid-HOLD: immediate return to the reset values; a pending result is lost.
- Compare is unsigned by default.
- count never wraps: it saturates at WIN_LEN-1 by construction because the block leaves ACCUM on the last sample.

Optional Feature:
- Macro: PEAK_SIGNED_EN.
- Defined: samples are two's-complement signed and all max/min comparisons are signed (0x80000000 is the most negative).
- Undefined: unsigned comparison.
- Ports and timing are identical in both builds.

Decomposition:
- Shared package cmp_pkg:
  - state enum {FIRST, ACCUM, HOLD}.
  - constant DATA_W=32.
  - function computing IDX_W from WIN_LEN.
- One natural sub-module: peak_cmp_stage. Purely combinational; takes sample, run_max and run_min; returns upd_max, upd_min and neq. It is instantiated once and holds the signed/unsigned selection.
- The FSM, counters and output registers live in the top module.

Test Plan:
- WIN_LEN=4, feed 5, 9, 2, 9 back-to-back with out_ready=1 -> out_max=9, max_idx=1 (tie keeps first), out_min=2, min_idx=2, all_eq=0; out_valid one cycle after the 4th accept.
- WIN_LEN=4, four samples of 0x12345678 -> max=min=0x12345678, both idx=0, all_eq=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> outputs stable, in_ready=0, no sample lost; after the handshake the next window starts at idx 0.
- Feed 0xFFFFFFFF then 0x00000001 -> unsigned build: max=0xFFFFFFFF, min=0x00000001; with PEAK_SIGNED_EN: max=0x00000001, min=0xFFFFFFFF.
- Assert clear after 2 of 4 samples, then feed 7, 3, 8, 1 -> result max=8/idx2, min=1/idx3; pre-clear samples are ignored.
- rst_n low mid-HOLD -> out_valid drops immediately, all outputs 0, in_ready=1 after release; WIN_LEN=1 run: single sample 42 -> max=min=42, out_valid next cycle.
